// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial two's-complement subtractor, LSB first
//
// Computes diff = a - b - bin one bit per clock through a single
// full-subtractor slice and a borrow flop, behind a start/busy/done handshake.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    operation request, accepted only in IDLE or DONE
//   a, b     minuend / subtrahend, captured on accepted start
//   bin      borrow-in, captured on accepted start
//   busy     high while bits are being processed
//   done     one-cycle pulse when diff/bout/overflow are fresh
//   diff     a - b - bin modulo 2^WIDTH, held until the next result
//   bout     unsigned borrow-out
//   overflow signed overflow of the subtraction

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  // Full-subtractor slice on the current LSBs.
  logic             a0, b0, d_bit, br_nx;
  logic [WIDTH-1:0] d_msb;
  logic [WIDTH-1:0] res_nx;
  logic             last_bit;

  always_comb begin
    a0       = a_sh_q[0];
    b0       = b_sh_q[0];
    d_bit    = a0 ^ b0 ^ br_q;
    br_nx    = (~a0 & b0) | (~(a0 ^ b0) & br_q);
    // Written as a masked OR so WIDTH=1 needs no special-case slice.
    d_msb    = '0;
    d_msb[WIDTH-1] = d_bit;
    res_nx   = (res_q >> 1) | d_msb;
    last_bit = (cnt_q == CW'(WIDTH - 1));
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = bin;
          cnt_d   = '0;
          res_d   = '0;
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        br_d   = br_nx;
        res_d  = res_nx;
        cnt_d  = cnt_q + CW'(1);
        if (last_bit) begin
          diff_d  = res_nx;
          bout_d  = br_nx;
          // Borrow into the MSB differs from borrow out of it.
          ovf_d   = br_q ^ br_nx;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q == S_SHIFT);
  assign done     = (state_q == S_DONE);
  assign diff     = diff_q;
  assign bout     = bout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         busy, done, bout, overflow;
  logic [W-1:0] diff;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] exp_diff = '0;
  logic         exp_bout = 1'b0;
  logic         exp_ovf  = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
    int ua, ub, sa, sb, sres;
    ua = int'(ma);
    ub = int'(mb);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    sres = sa - sb - int'(mbin);
    exp_diff = W'((ua - ub - int'(mbin)) & 255);
    exp_bout = (ua < ub + int'(mbin));
    exp_ovf  = (sres > 127) || (sres < -128);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one operation; operands are scrambled after capture.
  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic obin);
    logic [W-1:0] prev;
    prev  = exp_diff;
    a = oa; b = ob; bin = obin; start = 1'b1;
    tick();
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    chk("busy_after_accept", busy, 1);
    for (int i = 1; i < W; i++) begin
      tick();
      chk("busy_mid", {busy, done}, 2'b10);
      chk("diff_hold", diff, prev);
    end
    tick();
    model(oa, ob, obin);
    chk("done_pulse", {busy, done}, 2'b01);
    chk("diff", diff, exp_diff);
    chk("bout", bout, exp_bout);
    chk("overflow", overflow, exp_ovf);
    tick();
    chk("done_clear", done, 0);
    chk("diff_hold_idle", diff, exp_diff);
  endtask

  initial begin
    logic [W-1:0] na, nb;
    logic         nbin;

    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_flags", {bout, overflow}, 0);
    tick();
    rst_n = 1'b1;
    tick();

    run_op(8'h35, 8'h12, 1'b0);
    run_op(8'h12, 8'h35, 1'b0);
    run_op(8'h80, 8'h01, 1'b0);
    run_op(8'h7F, 8'hFF, 1'b0);
    run_op(8'h00, 8'h00, 1'b1);
    run_op(8'hFF, 8'hFF, 1'b1);
    for (int k = 0; k < 16; k++)
      run_op(W'($urandom), W'($urandom), 1'($urandom));

    // start during SHIFT must be ignored
    a = 8'h35; b = 8'h12; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    a = 8'hFF; b = 8'h00; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < W - 3; i++) tick();
    chk("ignore_done", done, 1);
    chk("ignore_diff", diff, 8'h23);
    tick();

    // asynchronous reset in the middle of an operation
    a = 8'h40; b = 8'h01; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_diff", diff, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      tick();
      chk("arst_no_done", {busy, done}, 0);
    end
    exp_diff = '0;
    run_op(8'h9C, 8'h3A, 1'b1);

    // start held high: one result every W+1 cycles
    na = W'($urandom); nb = W'($urandom); nbin = 1'($urandom);
    a = na; b = nb; bin = nbin; start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      logic [W-1:0] prev;
      prev = exp_diff;
      tick();
      model(na, nb, nbin);
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      chk("b2b_busy", {busy, done}, 2'b10);
      for (int i = 1; i < W; i++) begin
        tick();
        chk("b2b_hold", {busy, done, diff}, {2'b10, prev});
      end
      tick();
      chk("b2b_done", {busy, done}, 2'b01);
      chk("b2b_result", {diff, bout, overflow}, {exp_diff, exp_bout, exp_ovf});
      na = W'($urandom); nb = W'($urandom); nbin = 1'($urandom);
      a = na; b = nb; bin = nbin;
    end
    start = 1'b0;
    tick();
    tick();
    chk("b2b_idle", {busy, done}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
